// File: rtl/m_uart_imem_loader.sv
// UART 8N1 program loader: A5, CNT_H, CNT_L, 4*N big-endian data bytes.
// Define CHECKSUM_EN to expect a trailing modulo-256 sum byte.
module m_uart_imem_loader #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HDR_BYTE     = 8'hA5,
    parameter int         ADDR_W       = 12
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_rxd,
    output logic              r_we,
    output logic [ADDR_W-1:0] r_addr,
    output logic [31:0]       r_wdata,
    output logic              r_busy,
    output logic              r_done,
    output logic              r_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [16:0]   MAX_N = 17'd1 << ADDR_W;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_t;
    typedef enum logic [2:0] {S_HDR, S_CNTH, S_CNTL, S_DATA, S_CSUM, S_ERR} st_t;

    logic r_rx_s1, r_rx_s2;
    rx_t  r_rx_st, w_rx_st;
    logic [CW-1:0] r_clk_cnt, w_clk_cnt;
    logic [2:0] r_bit_idx, w_bit_idx;
    logic [7:0] r_shift, w_shift;
    logic r_bvalid, w_bvalid, r_ferr, w_ferr;

    st_t  r_st, w_st;
    logic [7:0]  r_cnth, w_cnth, r_sum, w_sum;
    logic [15:0] r_n, w_n;
    logic [16:0] r_wcnt, w_wcnt;
    logic [ADDR_W-1:0] r_waddr, w_waddr, w_addr;
    logic [1:0]  r_bidx, w_bidx;
    logic [31:0] r_asm, w_asm, w_wdata;
    logic w_we, w_busy, w_done, w_err;

    always_comb begin
        w_rx_st   = r_rx_st;
        w_clk_cnt = r_clk_cnt + 1'b1;
        w_bit_idx = r_bit_idx;
        w_shift   = r_shift;
        w_bvalid  = 1'b0;
        w_ferr    = 1'b0;
        unique case (r_rx_st)
            RX_IDLE: begin
                w_clk_cnt = '0;
                if (!r_rx_s2) w_rx_st = RX_START;
            end
            RX_START: if (r_clk_cnt == HALF) begin
                w_clk_cnt = '0;
                w_bit_idx = '0;
                w_rx_st   = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (r_clk_cnt == LAST) begin
                w_clk_cnt = '0;
                w_shift   = {r_rx_s2, r_shift[7:1]};
                w_bit_idx = r_bit_idx + 3'd1;
                if (r_bit_idx == 3'd7) w_rx_st = RX_STOP;
            end
            RX_STOP: if (r_clk_cnt == LAST) begin
                w_rx_st  = RX_IDLE;
                w_bvalid = r_rx_s2;
                w_ferr   = !r_rx_s2;
            end
            default: w_rx_st = RX_IDLE;
        endcase
    end

    always_comb begin
        w_st    = r_st;
        w_cnth  = r_cnth;
        w_sum   = r_sum;
        w_n     = r_n;
        w_wcnt  = r_wcnt;
        w_waddr = r_waddr;
        w_bidx  = r_bidx;
        w_asm   = r_asm;
        w_we    = 1'b0;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_busy  = r_busy;
        w_done  = r_done;
        w_err   = r_err;
        if (r_ferr && r_st != S_HDR && r_st != S_ERR) begin
            w_st   = S_ERR;
            w_busy = 1'b0;
            w_err  = 1'b1;
        end else if (r_bvalid) begin
            unique case (r_st)
                S_HDR: if (r_shift == HDR_BYTE) begin
                    w_st   = S_CNTH;
                    w_busy = 1'b1;
                    w_done = 1'b0;
                end
                S_CNTH: begin
                    w_cnth = r_shift;
                    w_sum  = r_shift;
                    w_st   = S_CNTL;
                end
                S_CNTL: begin
                    w_n     = {r_cnth, r_shift};
                    w_sum   = r_sum + r_shift;
                    w_waddr = '0;
                    w_wcnt  = '0;
                    w_bidx  = '0;
                    if (w_n == 16'd0) begin
`ifdef CHECKSUM_EN
                        w_st   = S_CSUM;
`else
                        w_st   = S_HDR;
                        w_busy = 1'b0;
                        w_done = 1'b1;
`endif
                    end else if ({1'b0, w_n} > MAX_N) begin
                        w_st   = S_ERR;
                        w_busy = 1'b0;
                        w_err  = 1'b1;
                    end else begin
                        w_st = S_DATA;
                    end
                end
                S_DATA: begin
                    w_asm  = {r_asm[23:0], r_shift};
                    w_sum  = r_sum + r_shift;
                    w_bidx = r_bidx + 2'd1;
                    if (r_bidx == 2'd3) begin
                        w_we    = 1'b1;
                        w_addr  = r_waddr;
                        w_wdata = w_asm;
                        w_waddr = r_waddr + 1'b1;
                        w_wcnt  = r_wcnt + 17'd1;
                        if (w_wcnt == {1'b0, r_n}) begin
`ifdef CHECKSUM_EN
                            w_st   = S_CSUM;
`else
                            w_st   = S_HDR;
                            w_busy = 1'b0;
                            w_done = 1'b1;
`endif
                        end
                    end
                end
`ifdef CHECKSUM_EN
                S_CSUM: begin
                    w_busy = 1'b0;
                    if (r_shift == r_sum) begin
                        w_st   = S_HDR;
                        w_done = 1'b1;
                    end else begin
                        w_st  = S_ERR;
                        w_err = 1'b1;
                    end
                end
`endif
                S_ERR: w_st = S_ERR;
                default: w_st = S_HDR;
            endcase
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_st   <= RX_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_bvalid  <= 1'b0;
            r_ferr    <= 1'b0;
            r_st      <= S_HDR;
            r_cnth    <= '0;
            r_sum     <= '0;
            r_n       <= '0;
            r_wcnt    <= '0;
            r_waddr   <= '0;
            r_bidx    <= '0;
            r_asm     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rx_s1   <= w_rxd;
            r_rx_s2   <= r_rx_s1;
            r_rx_st   <= w_rx_st;
            r_clk_cnt <= w_clk_cnt;
            r_bit_idx <= w_bit_idx;
            r_shift   <= w_shift;
            r_bvalid  <= w_bvalid;
            r_ferr    <= w_ferr;
            r_st      <= w_st;
            r_cnth    <= w_cnth;
            r_sum     <= w_sum;
            r_n       <= w_n;
            r_wcnt    <= w_wcnt;
            r_waddr   <= w_waddr;
            r_bidx    <= w_bidx;
            r_asm     <= w_asm;
            r_we      <= w_we;
            r_addr    <= w_addr;
            r_wdata   <= w_wdata;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_err     <= w_err;
        end
    end
endmodule

// File: tb/tb_m_uart_imem_loader.sv
// Directed bench for m_uart_imem_loader at CLKS_PER_BIT=8.
// Define CHECKSUM_EN to run the checksum variant.
module tb_m_uart_imem_loader;
    localparam int CPB = 8;
`ifdef CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        w_rxd = 1'b1;
    logic        r_we;
    logic [11:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_busy, r_done, r_err;

    int n_chk = 0;
    int n_err = 0;
    int we_cnt = 0;
    int we_run = 0;
    int we_max = 0;
    logic [31:0] m_data [16];
    logic [11:0] m_addr [16];
    logic        m_busy [16];
    logic        m_done [16];

    m_uart_imem_loader #(.CLKS_PER_BIT(CPB), .HDR_BYTE(8'hA5), .ADDR_W(12)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_rxd(w_rxd),
        .r_we(r_we), .r_addr(r_addr), .r_wdata(r_wdata),
        .r_busy(r_busy), .r_done(r_done), .r_err(r_err)
    );

    always #5 w_clk = ~w_clk;

    always @(negedge w_clk) begin
        if (r_we) begin
            if (we_cnt < 16) begin
                m_data[we_cnt] = r_wdata;
                m_addr[we_cnt] = r_addr;
                m_busy[we_cnt] = r_busy;
                m_done[we_cnt] = r_done;
            end
            we_cnt = we_cnt + 1;
            we_run = we_run + 1;
            if (we_run > we_max) we_max = we_run;
        end else begin
            we_run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tx(input logic [7:0] b, input logic stop = 1'b1);
        @(negedge w_clk);
        w_rxd = 1'b0;
        repeat (CPB) @(negedge w_clk);
        for (int i = 0; i < 8; i++) begin
            w_rxd = b[i];
            repeat (CPB) @(negedge w_clk);
        end
        w_rxd = stop;
        repeat (CPB) @(negedge w_clk);
        w_rxd = 1'b1;
        repeat (2) @(negedge w_clk);
    endtask

    task automatic do_reset();
        w_rxd = 1'b1;
        @(negedge w_clk);
        w_rst_n = 1'b0;
        repeat (3) @(negedge w_clk);
        w_rst_n = 1'b1;
        repeat (3) @(negedge w_clk);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge w_clk);
        #1;
        chk("rst_we", r_we, 0);
        chk("rst_addr", r_addr, 0);
        chk("rst_wdata", r_wdata, 0);
        chk("rst_busy", r_busy, 0);
        chk("rst_done", r_done, 0);
        chk("rst_err", r_err, 0);
        w_rst_n = 1'b1;
        repeat (200) @(negedge w_clk);
        chk("idle_we", we_cnt, 0);

        tx(8'hA5);
        chk("f1_busy_hdr", r_busy, 1);
        chk("f1_done_hdr", r_done, 0);
        tx(8'h00); tx(8'h02);
        tx(8'h12); tx(8'h34); tx(8'h56); tx(8'h78);
        chk("f1_we_mid", we_cnt, 1);
        tx(8'hDE); tx(8'hAD); tx(8'hBE); tx(8'hEF);
        if (CS) tx(8'h4E);
        repeat (20) @(negedge w_clk);
        chk("f1_cnt", we_cnt, 2);
        chk("f1_a0", m_addr[0], 0);
        chk("f1_d0", m_data[0], 32'h12345678);
        chk("f1_b0", m_busy[0], 1);
        chk("f1_a1", m_addr[1], 1);
        chk("f1_d1", m_data[1], 32'hDEADBEEF);
        chk("f1_b1", m_busy[1], CS ? 1 : 0);
        chk("f1_dn1", m_done[1], CS ? 0 : 1);
        chk("f1_busy", r_busy, 0);
        chk("f1_done", r_done, 1);
        chk("f1_hold_a", r_addr, 1);
        chk("f1_hold_d", r_wdata, 32'hDEADBEEF);
        chk("we_width", we_max, 1);

        tx(8'h00); tx(8'hFF);
        chk("junk_done", r_done, 1);
        chk("junk_busy", r_busy, 0);
        tx(8'hA5); tx(8'h00); tx(8'h00);
        if (CS) tx(8'h00);
        repeat (10) @(negedge w_clk);
        chk("n0_cnt", we_cnt, 2);
        chk("n0_done", r_done, 1);
        chk("n0_busy", r_busy, 0);

        tx(8'hA5);
        @(negedge w_clk); w_rxd = 1'b0;
        @(negedge w_clk); w_rxd = 1'b1;
        repeat (20) @(negedge w_clk);
        tx(8'h00); tx(8'h01);
        tx(8'hAA); tx(8'hBB); tx(8'hCC); tx(8'hDD);
        if (CS) tx(8'h0F);
        repeat (10) @(negedge w_clk);
        chk("gl_cnt", we_cnt, 3);
        chk("gl_a", m_addr[2], 0);
        chk("gl_d", m_data[2], 32'hAABBCCDD);
        chk("gl_done", r_done, 1);

        tx(8'hA5); tx(8'h00); tx(8'h01); tx(8'h11); tx(8'h22);
        @(negedge w_clk); w_rxd = 1'b0;
        repeat (CPB) @(negedge w_clk);
        for (int i = 0; i < 3; i++) begin
            w_rxd = 1'b1;
            repeat (CPB) @(negedge w_clk);
        end
        #2;
        w_rst_n = 1'b0;
        w_rxd = 1'b1;
        #1;
        chk("mr_we", r_we, 0);
        chk("mr_wdata", r_wdata, 0);
        chk("mr_busy", r_busy, 0);
        chk("mr_done", r_done, 0);
        chk("mr_err", r_err, 0);
        repeat (3) @(negedge w_clk);
        w_rst_n = 1'b1;
        repeat (200) @(negedge w_clk);
        chk("mr_cnt", we_cnt, 3);
        chk("mr_busy2", r_busy, 0);

        tx(8'hA5); tx(8'h00); tx(8'h01); tx(8'h11); tx(8'h22);
        tx(8'h33, 1'b0);
        repeat (200) @(negedge w_clk);
        chk("fe_err", r_err, 1);
        chk("fe_busy", r_busy, 0);
        chk("fe_cnt", we_cnt, 3);
        tx(8'hA5); tx(8'h00); tx(8'h01);
        tx(8'h01); tx(8'h02); tx(8'h03); tx(8'h04);
        if (CS) tx(8'h0B);
        repeat (10) @(negedge w_clk);
        chk("fe_lock_cnt", we_cnt, 3);
        chk("fe_lock_err", r_err, 1);
        chk("fe_lock_busy", r_busy, 0);
        chk("fe_lock_done", r_done, 0);
        do_reset();
        chk("fe_clr", r_err, 0);

        tx(8'hA5); tx(8'h10); tx(8'h01);
        repeat (10) @(negedge w_clk);
        chk("big_err", r_err, 1);
        chk("big_busy", r_busy, 0);
        chk("big_cnt", we_cnt, 3);
        do_reset();

`ifdef CHECKSUM_EN
        base = we_cnt;
        tx(8'hA5); tx(8'h00); tx(8'h01);
        tx(8'h01); tx(8'h02); tx(8'h03); tx(8'h04); tx(8'h0B);
        repeat (10) @(negedge w_clk);
        chk("cs_cnt", we_cnt, base + 1);
        chk("cs_a", m_addr[base], 0);
        chk("cs_d", m_data[base], 32'h01020304);
        chk("cs_done", r_done, 1);
        chk("cs_err", r_err, 0);
        tx(8'hA5); tx(8'h00); tx(8'h01);
        tx(8'h01); tx(8'h02); tx(8'h03); tx(8'h04); tx(8'h0C);
        repeat (10) @(negedge w_clk);
        chk("csb_err", r_err, 1);
        chk("csb_done", r_done, 0);
        chk("csb_busy", r_busy, 0);
`else
        base = we_cnt;
        chk("nocs_cnt", base, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/m_uart_imem_loader.md
Name: m_uart_imem_loader

Overview:
- Serial program loader that writes instruction/data words into m_memory through its write port (w_we/w_addr/w_din), the write side of the memory the processor reads.
- Receives 8N1 UART bytes from a host, parses a framed load command, assembles big-endian 32-bit words and issues one-cycle write strobes at sequential word addresses.
- Holds the processor in reset (r_busy) while a load is in progress.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
- HDR_BYTE, 8'hA5, frame header byte.
- ADDR_W, 12, word-address width; maximum loadable word count is 2**ADDR_W.

Ports:
- w_clk  input  1  system clock
- w_rst_n  input  1  asynchronous active-low reset
- w_rxd  input  1  UART receive line, idle high, asynchronous to w_clk
- r_we  output  1  memory write strobe, one cycle per word
- r_addr  output  ADDR_W  word address for the write
- r_wdata  output  32  word to write
- r_busy  output  1  load in progress; the top level ORs this into the processor reset
- r_done  output  1  last load completed successfully
- r_err  output  1  sticky error flag

Behaviour:
Reset:
- Async assert of w_rst_n: all outputs 0, FSM in S_HDR, receiver idle, synchronizer flops set to 1.
- Reset mid-load discards partial words. No further writes are issued.

Receiver:
- w_rxd passes through a 2-flop synchronizer.
- A falling edge in the idle state starts a bit counter. The start bit is re-checked at CLKS_PER_BIT/2; if high, it is ignored as a glitch and the receiver returns to idle.
- Data bits are sampled every CLKS_PER_BIT from the start-bit midpoint, LSB first.
- The stop bit is sampled at its midpoint. Stop=1 emits a 1-cycle byte_valid with the byte; stop=0 is a framing error.

Frame: HDR_BYTE, CNT_H, CNT_L, then 4*N data bytes (MSB first per word), where N = {CNT_H,CNT_L}.

FSM:
- S_HDR: byte==HDR_BYTE -> S_CNTH, and set r_busy=1, r_done=0. Other bytes are ignored.
- S_CNTH: latch high count byte -> S_CNTL.
- S_CNTL: latch low count byte.
  - N==0 -> S_HDR with r_busy=0, r_done=1.
  - N > 2**ADDR_W -> S_ERR.
  - Otherwise -> S_DATA, with word address 0 and byte index 0.
- S_DATA: shift each byte into a 32-bit assembly register. When the 4th byte arrives:
  - The next cycle drives r_we=1, r_wdata=word, r_addr=current address for exactly one cycle. r_addr and r_wdata are held stable afterwards.
  - The address increments.
  - When the word count reaches N -> S_HDR, r_busy=0, r_done=1, in the same cycle as the final r_we.
- S_ERR: r_err=1, r_busy=0, no writes. Only reset leaves this state.

Rules:
- A framing error in any state other than S_HDR -> S_ERR. In S_HDR the byte is dropped silently.
- A new header after r_done restarts the load: r_done clears and the address restarts at 0.
- r_addr wraps within ADDR_W bits. N==2**ADDR_W writes addresses 0..2**ADDR_W-1 exactly once.
- There is no write back-pressure; memory accepts a write every cycle.

Optional Feature:
CHECKSUM_EN:
- Defined: after the data bytes, one extra byte is expected, equal to the 8-bit modulo-256 sum of CNT_H, CNT_L and all data bytes.
  - Words are still written as they arrive.
  - Match -> r_done=1. Mismatch -> S_ERR (r_err=1, r_done=0).
  - For N==0 the checksum byte follows CNT_L.
- Undefined: no checksum byte; completion occurs on the final word, as described under Behaviour.

Test Plan (CLKS_PER_BIT=8 unless stated):
- Reset with w_rxd idle -> all outputs 0; 200 idle cycles -> r_we never asserted.
- Send A5 00 02 12 34 56 78 DE AD BE EF -> r_we pulses twice (1 cycle each): addr 0 data 32'h12345678, then addr 1 data 32'hDEADBEEF. r_busy goes 1 after A5 and 0 at the second write; r_done=1.
- Send 00 FF A5 00 00 -> leading bytes ignored; no r_we; r_done=1, r_busy=0.
- Send A5 00 01 11 22, then a byte with stop bit forced 0 -> r_err=1, r_busy=0, no r_we. A subsequent valid frame is ignored until w_rst_n pulses low.
- 1-cycle low glitch on w_rxd while idle -> no byte accepted. Drop w_rst_n mid-way through the 3rd data byte -> outputs 0 immediately, and no write for the partial word.
- With CHECKSUM_EN, send A5 00 01 01 02 03 04 0B -> write of 32'h01020304 at addr 0, r_done=1. Repeat with checksum 0C -> r_err=1, r_done=0.
